// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: FSM state encoding,
// the bundle of pipeline-register controls and its canned values.
package mips_ctrl_pkg;

    localparam int NB_REG = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3,
        ST_STEP   = 3'd4
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_bubble;
    } ctrl_t;

    // Pipeline fully frozen.
    localparam ctrl_t CTRL_OFF = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                   idex_en: 1'b0, idex_bubble: 1'b0};
    // Front end held, NOP controls injected into ID/EX, back end keeps moving.
    localparam ctrl_t CTRL_NOP = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                   idex_en: 1'b1, idex_bubble: 1'b1};
    // Normal advance of every stage.
    localparam ctrl_t CTRL_GO  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                   idex_en: 1'b1, idex_bubble: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID instruction's sources and
// the destination of the load sitting in ID/EX. Register 0 never hazards.
module load_use_detect #(
    parameter int NB_REG = 5
) (
    input  logic              ex_mem_read,
    input  logic [NB_REG-1:0] ex_rw,
    input  logic [NB_REG-1:0] id_rs,
    input  logic [NB_REG-1:0] id_rt,
    input  logic              id_uses_rt,
    output logic              hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_rw == id_rs);
    assign rt_hit = id_uses_rt && (ex_rw == id_rt);
    assign hazard = ex_mem_read && (ex_rw != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline controller for the IF/ID and ID/EX registers: load-use stalls,
// branch flush, halt drain and debug run gating.
// Optional single-step support is compiled in with `define STEP_MODE_EN.
module hazard_stall_unit #(
    parameter int NB_REG    = mips_ctrl_pkg::NB_REG,
    parameter int NB_CNT    = 16,
    parameter int DRAIN_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_i,
    input  logic              step_i,
    input  logic [NB_REG-1:0] id_rs_i,
    input  logic [NB_REG-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic [NB_REG-1:0] ex_rw_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_halt_i,
    input  logic              wb_halt_i,
    input  logic              branch_taken_i,
    output logic              pc_en_o,
    output logic              ifid_en_o,
    output logic              ifid_flush_o,
    output logic              idex_en_o,
    output logic              idex_bubble_o,
    output logic              halted_o,
    output logic [NB_CNT-1:0] stall_cnt_o,
    output logic [NB_CNT-1:0] cycle_cnt_o
);
    import mips_ctrl_pkg::*;

    localparam int          DW         = $clog2(DRAIN_MAX + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

    state_t          state;
    state_t          next_state;
    ctrl_t           ctrl;
    logic            hazard;
    logic            active;
    logic [DW-1:0]   drain_cnt;

    load_use_detect #(.NB_REG(NB_REG)) u_lud (
        .ex_mem_read (ex_mem_read_i),
        .ex_rw       (ex_rw_i),
        .id_rs       (id_rs_i),
        .id_rt       (id_rt_i),
        .id_uses_rt  (id_uses_rt_i),
        .hazard      (hazard)
    );

`ifdef STEP_MODE_EN
    assign active = (state == ST_RUN) || (state == ST_STEP);
`else
    assign active = (state == ST_RUN);
    logic unused_step;
    assign unused_step = step_i;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state decode; run level wins over a concurrent step pulse
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (run_i) next_state = ST_RUN;
`ifdef STEP_MODE_EN
                else if (step_i) next_state = ST_STEP;
`endif
            end
            ST_RUN: begin
                if (ex_halt_i)  next_state = ST_DRAIN;
                else if (!run_i) next_state = ST_IDLE;
            end
`ifdef STEP_MODE_EN
            ST_STEP:   next_state = ex_halt_i ? ST_DRAIN : ST_IDLE;
`endif
            ST_DRAIN: begin
                if (wb_halt_i || drain_cnt == DRAIN_LAST) next_state = ST_HALTED;
            end
            ST_HALTED: next_state = ST_HALTED;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Output decode; hazard is Mealy so the stall lands in the same cycle
    always_comb begin
        ctrl = CTRL_OFF;
        if (active) begin
            if (hazard) begin
                ctrl = CTRL_NOP;
            end else begin
                ctrl            = CTRL_GO;
                ctrl.ifid_flush = branch_taken_i;
            end
        end else if (state == ST_DRAIN) begin
            ctrl = CTRL_NOP;
        end
    end

    assign pc_en_o       = ctrl.pc_en;
    assign ifid_en_o     = ctrl.ifid_en;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_en_o     = ctrl.idex_en;
    assign idex_bubble_o = ctrl.idex_bubble;
    assign halted_o      = (state == ST_HALTED);

    // Drain timeout counter, restarts from zero on every entry to DRAIN
    always_ff @(posedge clock) begin
        if (reset || state != ST_DRAIN) drain_cnt <= '0;
        else                            drain_cnt <= drain_cnt + 1'b1;
    end

    // Saturating performance counters
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_o <= '0;
            cycle_cnt_o <= '0;
        end else begin
            if (active && hazard && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (ctrl.idex_en && cycle_cnt_o != '1)     cycle_cnt_o <= cycle_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed steps from the test
// plan followed by a randomized run, all checked against a cycle model.
// Narrow counters are used so saturation is reached quickly.
module tb_hazard_stall_unit;

    localparam int NB_REG    = 5;
    localparam int NB_CNT    = 4;
    localparam int DRAIN_MAX = 8;
    localparam int CNT_MAX   = (1 << NB_CNT) - 1;

    logic              clock = 1'b0;
    logic              reset, run_i, step_i, id_uses_rt_i;
    logic [NB_REG-1:0] id_rs_i, id_rt_i, ex_rw_i;
    logic              ex_mem_read_i, ex_halt_i, wb_halt_i, branch_taken_i;
    logic              pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_bubble_o, halted_o;
    logic [NB_CNT-1:0] stall_cnt_o, cycle_cnt_o;

    hazard_stall_unit #(.NB_REG(NB_REG), .NB_CNT(NB_CNT), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clock(clock), .reset(reset), .run_i(run_i), .step_i(step_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .ex_rw_i(ex_rw_i), .ex_mem_read_i(ex_mem_read_i), .ex_halt_i(ex_halt_i),
        .wb_halt_i(wb_halt_i), .branch_taken_i(branch_taken_i),
        .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .ifid_flush_o(ifid_flush_o),
        .idex_en_o(idex_en_o), .idex_bubble_o(idex_bubble_o), .halted_o(halted_o),
        .stall_cnt_o(stall_cnt_o), .cycle_cnt_o(cycle_cnt_o)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Behavioural model: what the processor is doing, as independent flags
    bit m_running, m_stepping, m_draining, m_halted;
    int m_drain_cycles;
    int m_stalls, m_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit load_use();
        int rw;
        rw = int'(ex_rw_i);
        if (!ex_mem_read_i || rw == 0) return 0;
        if (rw == int'(id_rs_i)) return 1;
        return id_uses_rt_i && rw == int'(id_rt_i);
    endfunction

    // Check outputs mid-cycle, then advance the model on the clock edge
    task automatic tick();
        bit live, hz, feed;
        @(negedge clock);
        live = m_running || m_stepping;
        hz   = load_use();
        feed = live && !hz;
        chk("pc_en",       pc_en_o,       feed);
        chk("ifid_en",     ifid_en_o,     feed);
        chk("ifid_flush",  ifid_flush_o,  feed && branch_taken_i);
        chk("idex_en",     idex_en_o,     live || m_draining);
        chk("idex_bubble", idex_bubble_o, (live && hz) || m_draining);
        chk("halted",      halted_o,      m_halted);
        chk("stall_cnt",   stall_cnt_o,   m_stalls);
        chk("cycle_cnt",   cycle_cnt_o,   m_cycles);
        @(posedge clock);
        if (reset) begin
            {m_running, m_stepping, m_draining, m_halted} = '0;
            m_drain_cycles = 0; m_stalls = 0; m_cycles = 0;
        end else begin
            if (live && hz) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
            if (live || m_draining) m_cycles = (m_cycles < CNT_MAX) ? m_cycles + 1 : CNT_MAX;
            if (m_halted) begin
                // sticky
            end else if (m_draining) begin
                m_drain_cycles++;
                if (wb_halt_i || m_drain_cycles == DRAIN_MAX) begin
                    m_draining = 0; m_halted = 1;
                end
            end else if (live) begin
                if (ex_halt_i) begin
                    m_running = 0; m_stepping = 0; m_draining = 1; m_drain_cycles = 0;
                end else if (m_stepping || !run_i) begin
                    m_running = 0; m_stepping = 0;
                end
            end else begin
                if (run_i) m_running = 1;
`ifdef STEP_MODE_EN
                else if (step_i) m_stepping = 1;
`endif
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        run_i = 0; step_i = 0; id_rs_i = 0; id_rt_i = 0; id_uses_rt_i = 0;
        ex_rw_i = 0; ex_mem_read_i = 0; ex_halt_i = 0; wb_halt_i = 0; branch_taken_i = 0;
    endtask

    initial begin
        reset = 1; clear_inputs();
        @(posedge clock); #1;
        // reset state
        tick();
        reset = 0; tick();
        // start running: one IDLE cycle, then RUN
        run_i = 1; tick(); tick(); tick(); tick();
        // load-use on rs, then the same with r0 as destination
        ex_mem_read_i = 1; ex_rw_i = 5; id_rs_i = 5; tick(); tick();
        ex_rw_i = 0; id_rs_i = 0; tick();
        // rt only matters when the instruction reads it
        id_rs_i = 1; id_rt_i = 7; ex_rw_i = 7; id_uses_rt_i = 0; tick();
        id_uses_rt_i = 1; tick();
        // branch flush, then branch colliding with a stall
        ex_mem_read_i = 0; branch_taken_i = 1; tick();
        ex_mem_read_i = 1; tick();
        ex_mem_read_i = 0; branch_taken_i = 0; tick();
        // halt drain ended by write-back
        ex_halt_i = 1; tick();
        ex_halt_i = 0; run_i = 0; tick(); tick(); tick();
        wb_halt_i = 1; tick();
        wb_halt_i = 0; tick(); run_i = 1; tick();
        // drain timeout
        reset = 1; tick(); reset = 0; tick(); tick();
        ex_halt_i = 1; tick(); ex_halt_i = 0;
        repeat (11) tick();
        // reset in the middle of a drain
        reset = 1; tick(); reset = 0; tick(); tick();
        ex_halt_i = 1; tick(); ex_halt_i = 0; tick(); tick();
        reset = 1; tick(); reset = 0; run_i = 0; tick(); tick();
        // run drop freezes the pipe
        run_i = 1; tick(); tick(); run_i = 0; tick(); tick();
`ifdef STEP_MODE_EN
        // single step from IDLE, and a step pulse while in STEP is dropped
        step_i = 1; tick(); tick(); step_i = 0; tick(); tick();
        run_i = 1; step_i = 1; tick(); step_i = 0; tick(); run_i = 0; tick(); tick();
`endif
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 149) == 0);
            run_i          = ($urandom_range(0, 7) != 0);
            step_i         = ($urandom_range(0, 3) == 0);
            id_rs_i        = NB_REG'($urandom_range(0, 7));
            id_rt_i        = NB_REG'($urandom_range(0, 7));
            ex_rw_i        = NB_REG'($urandom_range(0, 7));
            id_uses_rt_i   = $urandom_range(0, 1);
            ex_mem_read_i  = $urandom_range(0, 1);
            ex_halt_i      = ($urandom_range(0, 39) == 0);
            wb_halt_i      = ($urandom_range(0, 5) == 0);
            branch_taken_i = ($urandom_range(0, 3) == 0);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
